round_key_store: RTL

Parametrised round-key store: successor to the single-context AES subkey memory. Holds NUM_CTX independent key contexts of NUM_RK round keys each, with per-entry valid bits, NUM_RD independent read channels using a request/grant handshake (requests stall until the entry is valid, replacing high-Z reads), and a per-context invalidate. It sits between the key-expansion engine (writer) and the encrypt/decrypt round datapaths (readers).

---
 rtl/round_key_store_pkg.sv | 20 ++
 rtl/round_key_store_rd_port.sv | 59 +++++
 rtl/round_key_store.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/round_key_store_pkg.sv
// Shared definitions for the round-key store: AES round-key counts,
// default key width, scrub FSM states and the index-width helper.
package round_key_store_pkg;

  localparam int AES_RK_128   = 11;
  localparam int AES_RK_192   = 13;
  localparam int AES_RK_256   = 15;
  localparam int RK_KEY_W_DEF = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_t;

  // Width of a field addressing n items; never narrower than one bit.
  function automatic int rk_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_key_store_rd_port.sv
// One read channel of the round-key store: combinational grant against the
// shared valid flags, then a registered response (valid, err, key).
module rk_rd_port #(
  parameter int KEY_W   = 128,
  parameter int NUM_RK  = 15,
  parameter int NUM_CTX = 2,
  parameter int CTX_W   = 1,
  parameter int IDX_W   = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     i_req,
  input  logic [CTX_W-1:0]                         i_ctx,
  input  logic [IDX_W-1:0]                         i_idx,
  input  logic [NUM_CTX-1:0][NUM_RK-1:0]           i_valid,
  input  logic [NUM_CTX-1:0][NUM_RK-1:0][KEY_W-1:0] i_mem,
  input  logic                                     i_scrub_busy,
  input  logic [CTX_W-1:0]                         i_scrub_ctx,
  output logic                                     o_gnt,
  output logic                                     o_valid,
  output logic                                     o_err,
  output logic [KEY_W-1:0]                         o_key
);

  localparam logic [CTX_W:0] LP_NCTX = (CTX_W+1)'(NUM_CTX);
  localparam logic [IDX_W:0] LP_NRK  = (IDX_W+1)'(NUM_RK);

  logic             w_oor;
  logic             w_hit;
  logic             w_blk;
  logic             r_valid;
  logic             r_err;
  logic [KEY_W-1:0] r_key;

  // Out-of-range requests are granted at once and answered with an error.
  assign w_oor = ({1'b0, i_ctx} >= LP_NCTX) || ({1'b0, i_idx} >= LP_NRK);
  assign w_hit = !w_oor && i_valid[i_ctx][i_idx];
  // The context being zeroized is locked out until the sweep finishes.
  assign w_blk = i_scrub_busy && (i_ctx == i_scrub_ctx);
  assign o_gnt = i_req && !w_blk && (w_oor || w_hit);

  // Response register: one pulse per grant; key holds between grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_key   <= '0;
    end else begin
      r_valid <= o_gnt;
      r_err   <= o_gnt && w_oor;
      if (o_gnt) r_key <= w_oor ? '0 : i_mem[i_ctx][i_idx];
    end
  end

  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_key   = r_key;

endmodule

// File: rtl/round_key_store.sv
// Multi-context round-key store with per-entry valid flags, NUM_RD
// request/grant read channels and per-context invalidate.
// Optional feature macro: ROUND_KEY_STORE_ZEROIZE_EN -- an accepted
// invalidate also sweeps zeros through the context's memory, one entry per
// cycle, locking out writes, invalidates and reads of that context.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int KEY_W   = RK_KEY_W_DEF,
  parameter int NUM_RK  = AES_RK_256,
  parameter int NUM_CTX = 2,
  parameter int NUM_RD  = 2,
  parameter int CTX_W   = rk_width(NUM_CTX),
  parameter int IDX_W   = rk_width(NUM_RK)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [CTX_W-1:0]          i_wr_ctx,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [KEY_W-1:0]          i_wr_key,
  input  logic                      i_inv_valid,
  output logic                      o_inv_ready,
  input  logic [CTX_W-1:0]          i_inv_ctx,
  input  logic [NUM_RD-1:0]         i_rd_req,
  input  logic [NUM_RD*CTX_W-1:0]   i_rd_ctx,
  input  logic [NUM_RD*IDX_W-1:0]   i_rd_idx,
  output logic [NUM_RD-1:0]         o_rd_gnt,
  output logic [NUM_RD-1:0]         o_rd_valid,
  output logic [NUM_RD-1:0]         o_rd_err,
  output logic [NUM_RD*KEY_W-1:0]   o_rd_key,
  output logic [NUM_CTX*NUM_RK-1:0] o_valid_bits,
  output logic                      o_scrub_busy
);

  localparam logic [CTX_W:0] LP_NCTX = (CTX_W+1)'(NUM_CTX);
  localparam logic [IDX_W:0] LP_NRK  = (IDX_W+1)'(NUM_RK);

  logic [NUM_CTX-1:0][NUM_RK-1:0][KEY_W-1:0] r_mem;
  logic [NUM_CTX-1:0][NUM_RK-1:0]            r_valid;
  logic                                      w_wr_acc;
  logic                                      w_inv_ok;
  logic                                      w_inv_acc;
  logic                                      w_scrub_busy;
  logic [CTX_W-1:0]                          w_scrub_ctx;

  // Out-of-range writes are dropped without touching any flag.
  assign w_wr_acc  = i_wr_valid && o_wr_ready &&
                     ({1'b0, i_wr_ctx} < LP_NCTX) && ({1'b0, i_wr_idx} < LP_NRK);
  assign w_inv_ok  = i_inv_valid && ({1'b0, i_inv_ctx} < LP_NCTX);
  assign w_inv_acc = w_inv_ok && o_inv_ready;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_RK - 1);

  scrub_state_t     r_state;
  scrub_state_t     w_state_nxt;
  logic [CTX_W-1:0] r_scrub_ctx;
  logic [IDX_W-1:0] r_scrub_cnt;

  // Scrub state, captured target context and sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_scrub_ctx <= '0;
      r_scrub_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_inv_acc) r_scrub_ctx <= i_inv_ctx;
      if (r_state == SCRUB)
        r_scrub_cnt <= (r_scrub_cnt == LP_LAST) ? '0 : r_scrub_cnt + 1'b1;
    end
  end

  // Next state and handshake/busy outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_wr_ready   = 1'b1;
    o_inv_ready  = 1'b1;
    w_scrub_busy = 1'b0;
    case (r_state)
      IDLE: if (w_inv_ok) w_state_nxt = SCRUB;
      SCRUB: begin
        w_scrub_busy = 1'b1;
        o_wr_ready   = 1'b0;
        o_inv_ready  = 1'b0;
        if (r_scrub_cnt == LP_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_scrub_ctx = r_scrub_ctx;
`else
  assign o_wr_ready   = 1'b1;
  assign o_inv_ready  = 1'b1;
  assign w_scrub_busy = 1'b0;
  assign w_scrub_ctx  = '0;
`endif

  // Key storage (not reset). The sweep skips entries still flagged valid:
  // only a write landing in the invalidate cycle can be, and it must survive.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[i_wr_ctx][i_wr_idx] <= i_wr_key;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    if ((r_state == SCRUB) && !r_valid[r_scrub_ctx][r_scrub_cnt])
      r_mem[r_scrub_ctx][r_scrub_cnt] <= '0;
`endif
  end

  // Valid flags: a same-cycle invalidate is applied before the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_inv_acc) r_valid[i_inv_ctx] <= '0;
      if (w_wr_acc)  r_valid[i_wr_ctx][i_wr_idx] <= 1'b1;
    end
  end

  assign o_valid_bits = r_valid;
  assign o_scrub_busy = w_scrub_busy;

  for (genvar ch = 0; ch < NUM_RD; ch++) begin : g_rd
    rk_rd_port #(
      .KEY_W  (KEY_W),
      .NUM_RK (NUM_RK),
      .NUM_CTX(NUM_CTX),
      .CTX_W  (CTX_W),
      .IDX_W  (IDX_W)
    ) u_rd (
      .clk         (clk),
      .reset       (reset),
      .i_req       (i_rd_req[ch]),
      .i_ctx       (i_rd_ctx[ch*CTX_W +: CTX_W]),
      .i_idx       (i_rd_idx[ch*IDX_W +: IDX_W]),
      .i_valid     (r_valid),
      .i_mem       (r_mem),
      .i_scrub_busy(w_scrub_busy),
      .i_scrub_ctx (w_scrub_ctx),
      .o_gnt       (o_rd_gnt[ch]),
      .o_valid     (o_rd_valid[ch]),
      .o_err       (o_rd_err[ch]),
      .o_key       (o_rd_key[ch*KEY_W +: KEY_W])
    );
  end

endmodule
